// File: rtl/pipeline_stall_controller.sv
// Hazard and stall sequencer for the 5-stage pipeline: per-stage load enables and flushes,
// a data-memory wait FSM with a timeout watchdog, and a saturating count of frozen-PC cycles.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dest,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [1:0]       state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0]       TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       mem_stall;
    logic       load_use;
    logic       active;

    always_comb begin
        active    = (cur_state == RUN) || (cur_state == MEM_WAIT);
        mem_stall = mem_access & ~mem_ready;
        load_use  = ex_mem_read && (ex_dest != 5'd0) &&
                    ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
    end

    // An abort (mem_access dropping) leaves MEM_WAIT exactly like a completion does.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            RUN, MEM_WAIT: begin
                if (mem_stall && (wait_cnt == TIMEOUT_LAST))
                    next_state = HALT;
                else if (mem_stall)
                    next_state = MEM_WAIT;
                else
                    next_state = RUN;
            end
            HALT:    next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    // Reset and HALT force every enable and flush low; otherwise hazards resolve by priority.
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_we    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (!reset && active) begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
            memwb_we = 1'b1;
            if (mem_stall) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_we     = 1'b0;
                exmem_we    = 1'b0;
                memwb_flush = 1'b1;
            end else if (load_use) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= RUN;
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
            stall_count <= '0;
        end else begin
            cur_state <= next_state;
            if (active && mem_stall)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;
            if (next_state == HALT)
                timeout_err <= 1'b1;
            if (active && !pc_we && (stall_count != CNT_MAX))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign state = cur_state;

endmodule
